// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a valid/ready byte FIFO in front of the serializer.
// The serializer pops the FIFO head and shifts it out LSB-first; back-to-back frames abut.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          Rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic [7:0]    fifo_head;
    logic          push;
    logic          pop;

    // Serializer state
    state_t        state_reg,    state_next;
    logic          tx_reg,       tx_next;
    logic [7:0]    shift_reg,    shift_next;
    logic [2:0]    bit_idx_reg,  bit_idx_next;
    logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
    logic          baud_last;

    // Ready comes from the registered count only, so a pop in the same cycle
    // does not let a push into a full FIFO.
    assign tx_ready   = (count_reg < DEPTH_C);
    assign push       = tx_valid && tx_ready;
    assign fifo_head  = mem[rd_ptr_reg];
    assign baud_last  = (baud_cnt_reg == BAUD_LAST);

    assign tx         = tx_reg;
    assign fifo_count = count_reg;
    assign busy       = (state_reg != IDLE) || (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        tx_next       = tx_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        baud_cnt_next = baud_cnt_reg;
        pop           = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next       = 1'b1;
                baud_cnt_next = '0;
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    tx_next       = shift_reg[0];
                    shift_next    = shift_reg >> 1;
                    bit_idx_next  = 3'd0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BW'(1);
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BW'(1);
                end
            end

            STOP: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BW'(1);
                end
            end

            default: begin
                tx_next       = 1'b1;
                baud_cnt_next = '0;
                state_next    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_reg    <= IDLE;
            tx_reg       <= 1'b1;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            baud_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            tx_reg       <= tx_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            baud_cnt_reg <= baud_cnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with 4 clocks per bit and a 4-entry FIFO.
// Outputs are sampled 1 time unit after each rising edge; expected frames are built from the byte value.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       Rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of frame bit k (0 = start, 1..8 = data LSB-first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0)      return 1'b0;
        else if (k == 9) return 1'b1;
        else             return b[k-1];
    endfunction

    // Checks frame cycles first..last of byte b, starting at the current sample point.
    task automatic check_frame(input logic [7:0] b, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            chk($sformatf("tx_%02h_cyc%0d", b, i), 32'(tx), 32'(frame_bit(b, i / CPB)));
            chk($sformatf("busy_%02h_cyc%0d", b, i), 32'(busy), 32'd1);
            step();
        end
    endtask

    initial begin
        Rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) step();
        Rst = 1'b0;

        // Reset state
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);

        // Idle line for 1000 cycles
        for (int i = 0; i < 1000; i++) begin
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_ready", 32'(tx_ready), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            step();
        end

        // Single byte 0xA5
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        step();
        tx_valid = 1'b0;
        chk("a5_count_after_push", 32'(fifo_count), 32'd1);
        chk("a5_tx_before_pop", 32'(tx), 32'd1);
        step();
        check_frame(8'hA5, 0, 39);
        chk("a5_done_busy", 32'(busy), 32'd0);
        chk("a5_done_tx", 32'(tx), 32'd1);
        chk("a5_done_count", 32'(fifo_count), 32'd0);
        repeat (5) step();

        // Back-to-back 0x00 then 0xFF; data changes after accept must not matter
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        step();
        tx_data  = 8'hFF;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'h5A;
        chk("b2b_count_first", 32'(fifo_count), 32'd1);
        check_frame(8'h00, 0, 39);
        chk("b2b_count_second", 32'(fifo_count), 32'd0);
        check_frame(8'hFF, 0, 39);
        chk("b2b_done_tx", 32'(tx), 32'd1);
        chk("b2b_done_busy", 32'(busy), 32'd0);
        repeat (5) step();

        // Fill the FIFO while the first frame shifts, then hold 0x66 while full
        tx_valid = 1'b1;
        tx_data  = 8'h11; step();
        tx_data  = 8'h22; step();
        tx_data  = 8'h33; step();
        tx_data  = 8'h44; step();
        tx_data  = 8'h55; step();
        tx_data  = 8'h66;
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(tx_ready), 32'd0);
        check_frame(8'h11, 3, 39);
        chk("full_pop_count", 32'(fifo_count), 32'd3);
        chk("full_pop_ready", 32'(tx_ready), 32'd1);
        step();
        tx_valid = 1'b0;
        chk("full_66_accepted", 32'(fifo_count), 32'd4);
        check_frame(8'h22, 1, 39);
        chk("full_count_33", 32'(fifo_count), 32'd3);
        check_frame(8'h33, 0, 39);
        chk("full_count_44", 32'(fifo_count), 32'd2);
        check_frame(8'h44, 0, 39);
        chk("full_count_55", 32'(fifo_count), 32'd1);
        check_frame(8'h55, 0, 39);
        chk("full_count_66", 32'(fifo_count), 32'd0);
        check_frame(8'h66, 0, 39);
        chk("full_done_tx", 32'(tx), 32'd1);
        chk("full_done_busy", 32'(busy), 32'd0);
        repeat (5) step();

        // Reset during data bit 3 of the first of two queued frames
        tx_valid = 1'b1;
        tx_data  = 8'h3C; step();
        tx_data  = 8'hC3; step();
        tx_valid = 1'b0;
        chk("mid_count", 32'(fifo_count), 32'd1);
        check_frame(8'h3C, 0, 17);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(tx_ready), 32'd1);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("post_rst_tx", 32'(tx), 32'd1);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
